divider_param: RTL and testbench
================================

DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until finish is asserted.
REQ-009 SHALL have port finish  output  1  one-cycle pulse marking quo/rem/div_zero valid.
REQ-010 SHALL have port quo  output  WIDTH  quotient.
REQ-011 SHALL have port rem  output  WIDTH  remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero for the last completed division.

Function
REQ-013 SHALL implement a restoring shift/subtract algorithm with one quotient bit per cycle, using a 2*WIDTH+1-bit remainder/quotient shift register and a WIDTH+1-bit subtractor.
REQ-014 SHALL use states IDLE, RUN, FIX, DONE; IDLE->RUN on start; RUN->FIX after exactly WIDTH iterations (down-counter of width clog2(WIDTH)+1); FIX->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL, on the edge start is accepted, latch magnitudes |a|, |b| (when signed mode is active) plus sign of quotient (a xor b) and sign of remainder (sign of a).
REQ-016 SHALL assert finish only in DONE; for start sampled at edge N, finish is high in the cycle after edge N+WIDTH+2; latency is fixed regardless of operand values.
REQ-017 SHALL, in FIX, negate quotient and/or remainder per latched signs; remainder sign equals dividend sign; quotient truncates toward zero.
REQ-018 SHALL, when b == 0: quo = all ones, rem = a (unmodified), div_zero = 1, same latency.
REQ-019 SHALL, for signed overflow (a = most negative, b = -1): quo = a, rem = 0, div_zero = 0.
REQ-020 SHALL hold quo, rem, div_zero stable after finish until the next accepted start's FIX edge.
REQ-021 SHALL ignore start while busy or in DONE; start held high in IDLE launches back-to-back divisions (one idle cycle between finish and next busy).
REQ-022 SHALL ignore changes on a, b, is_signed while busy.

Reset
REQ-023 SHALL, when rst is high at a rising edge, enter IDLE and clear busy, finish, quo, rem, div_zero and the iteration counter to 0, including mid-operation; the aborted division produces no finish.
REQ-024 SHALL give rst priority over start on the same edge.

Configuration
REQ-025 SHALL compile signed support only when macro DIVIDER_PARAM_SIGNED_EN is defined: sign latching, FIX negation and the REQ-019 case present, is_signed honoured.
REQ-026 SHALL, without DIVIDER_PARAM_SIGNED_EN, ignore is_signed, treat all operands as unsigned, omit negation logic, and leave FIX as a pass-through cycle so latency is identical.

Verification
REQ-027 SHALL cover WIDTH=32 unsigned a=100, b=7 -> quo=14, rem=2, div_zero=0, finish exactly 34 cycles after the start edge.
REQ-028 SHALL cover WIDTH=32 unsigned a=0xFFFFFFFF, b=1 -> quo=0xFFFFFFFF, rem=0; and a=5, b=0 -> quo=0xFFFFFFFF, rem=5, div_zero=1.
REQ-029 SHALL cover signed (macro defined) a=-7, b=2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF; a=0x80000000, b=0xFFFFFFFF -> quo=0x80000000, rem=0.
REQ-030 SHALL cover rst pulsed at iteration 10 of a division -> no finish, all outputs 0, next start (a=9, b=3) -> quo=3, rem=0.
REQ-031 SHALL cover WIDTH=8 with start held high over two operand sets (200/13, 17/17) -> results 15 r 5 then 1 r 0, each finish 10 cycles after its accepted start, and a mid-run change on a/b does not alter the result.
REQ-032 SHALL cover macro undefined with is_signed=1, a=0xFFFFFFF9, b=2 -> unsigned result quo=0x7FFFFFFC, rem=1.

Source files
------------

// File: rtl/divider_param.sv
// Multi-cycle restoring divider: one quotient bit per clock, fixed latency of WIDTH+2 cycles.
// Signed operand support is compiled in only when DIVIDER_PARAM_SIGNED_EN is defined.
module divider_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           stateReg, stateNext;
    logic [CW-1:0]    countReg;
    logic [2*WIDTH:0] shiftReg;
    logic [WIDTH-1:0] divisorReg;
    logic             zeroReg;
    logic [WIDTH-1:0] quoReg, remReg;
    logic             divZeroReg;

    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH:0]   trial, diff;
    logic             trialGeq;
    logic [2*WIDTH:0] stepShift;
    logic [WIDTH-1:0] rawQuo, rawRem, fixQuo, fixRem;
    logic             accept;
    logic             unusedTop;

    assign accept = (stateReg == IDLE) && start;

    // Upper half is shifted left one bit, then the divisor is trial-subtracted.
    assign trial     = shiftReg[2*WIDTH-1:WIDTH-1];
    assign diff      = trial - {1'b0, divisorReg};
    assign trialGeq  = trial >= {1'b0, divisorReg};
    assign stepShift = trialGeq ? {diff, shiftReg[WIDTH-2:0], 1'b1}
                                : {trial, shiftReg[WIDTH-2:0], 1'b0};

    // The partial remainder never exceeds the divisor, so the top bit is always zero here.
    assign unusedTop = shiftReg[2*WIDTH];
    assign rawQuo    = shiftReg[WIDTH-1:0];
    assign rawRem    = shiftReg[2*WIDTH-1:WIDTH];

`ifdef DIVIDER_PARAM_SIGNED_EN
    logic signA, signB;
    logic negQuoReg, negRemReg;

    assign signA = is_signed & a[WIDTH-1];
    assign signB = is_signed & b[WIDTH-1];
    assign magA  = signA ? -a : a;
    assign magB  = signB ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            negQuoReg <= 1'b0;
            negRemReg <= 1'b0;
        end else if (accept) begin
            negQuoReg <= signA ^ signB;
            negRemReg <= signA;
        end
    end

    // MIN / -1 needs no special case: |MIN| / 1 yields MIN's bit pattern with a positive sign.
    // Negating |a| restores a exactly, so divide-by-zero remainder comes out as the raw dividend.
    assign fixQuo = zeroReg   ? '1      : (negQuoReg ? -rawQuo : rawQuo);
    assign fixRem = negRemReg ? -rawRem : rawRem;
`else
    logic unusedSigned;

    assign unusedSigned = is_signed;
    assign magA   = a;
    assign magB   = b;
    assign fixQuo = rawQuo;
    assign fixRem = rawRem;
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (countReg == '0) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= IDLE;
            countReg   <= '0;
            shiftReg   <= '0;
            divisorReg <= '0;
            zeroReg    <= 1'b0;
            quoReg     <= '0;
            remReg     <= '0;
            divZeroReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: if (start) begin
                    countReg   <= CW'(WIDTH);
                    shiftReg   <= {{(WIDTH+1){1'b0}}, magA};
                    divisorReg <= magB;
                    zeroReg    <= (b == '0);
                end
                RUN: if (countReg != '0) begin
                    countReg <= countReg - CW'(1);
                    shiftReg <= stepShift;
                end
                FIX: begin
                    quoReg     <= fixQuo;
                    remReg     <= fixRem;
                    divZeroReg <= zeroReg;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (stateReg == RUN) || (stateReg == FIX);
    assign finish   = (stateReg == DONE);
    assign quo      = quoReg;
    assign rem      = remReg;
    assign div_zero = divZeroReg;

endmodule

// File: tb/tb_divider_param.sv
// Directed self-checking bench for divider_param at WIDTH=32 and WIDTH=8.
// Signed vectors are exercised when DIVIDER_PARAM_SIGNED_EN is defined.
module tb_divider_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, sgn32, busy32, finish32, dz32;
    logic [31:0] a32, b32, quo32, rem32;
    logic        start8, sgn8, busy8, finish8, dz8;
    logic [7:0]  a8, b8, quo8, rem8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divider_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
        .busy(busy32), .finish(finish32), .quo(quo32), .rem(rem32), .div_zero(dz32)
    );

    divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
        .busy(busy8), .finish(finish8), .quo(quo8), .rem(rem8), .div_zero(dz8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one 32-bit division, scramble inputs after acceptance, count cycles to finish.
    task automatic run32(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                         output int cyc, output logic busyAfter);
        a32 = av; b32 = bv; sgn32 = sg; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        a32 = ~av; b32 = bv + 32'd1; sgn32 = ~sg;
        busyAfter = busy32;
        cyc = 0;
        while (finish32 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        $display("div32 a=%h b=%h s=%0b -> quo=%h rem=%h dz=%0b after %0d cycles",
                 av, bv, sg, quo32, rem32, dz32, cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0;  sgn8 = 1'b0;  a8 = '0;  b8 = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy32 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy32); end
        checks++; if (finish32 !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish32); end
        checks++; if (quo32 !== 32'd0)   begin errors++; $display("FAIL reset_quo: got %h expected 0", quo32); end
        checks++; if (rem32 !== 32'd0)   begin errors++; $display("FAIL reset_rem: got %h expected 0", rem32); end
        checks++; if (dz32 !== 1'b0)     begin errors++; $display("FAIL reset_dz: got %b expected 0", dz32); end
        $display("reset applied");
    endtask

    task automatic test_unsigned_basic();
        int cyc; logic bz;
        run32(32'd100, 32'd7, 1'b0, cyc, bz);
        checks++; if (bz !== 1'b1)    begin errors++; $display("FAIL basic_busy: got %b expected 1", bz); end
        checks++; if (cyc != 34)      begin errors++; $display("FAIL basic_latency: got %0d expected 34", cyc); end
        checks++; if (quo32 !== 32'd14) begin errors++; $display("FAIL basic_quo: got %h expected 0000000e", quo32); end
        checks++; if (rem32 !== 32'd2)  begin errors++; $display("FAIL basic_rem: got %h expected 00000002", rem32); end
        checks++; if (dz32 !== 1'b0)    begin errors++; $display("FAIL basic_dz: got %b expected 0", dz32); end
        repeat (3) tick();
        checks++; if (quo32 !== 32'd14 || rem32 !== 32'd2)
            begin errors++; $display("FAIL basic_hold: got %h r %h expected 0000000e r 00000002", quo32, rem32); end
    endtask

    task automatic test_boundary();
        int cyc; logic bz;
        run32(32'hFFFF_FFFF, 32'd1, 1'b0, cyc, bz);
        checks++; if (quo32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_quo: got %h expected ffffffff", quo32); end
        checks++; if (rem32 !== 32'd0)         begin errors++; $display("FAIL max_rem: got %h expected 00000000", rem32); end
        tick();
        run32(32'd5, 32'd0, 1'b0, cyc, bz);
        checks++; if (cyc != 34)               begin errors++; $display("FAIL dz_latency: got %0d expected 34", cyc); end
        checks++; if (quo32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quo: got %h expected ffffffff", quo32); end
        checks++; if (rem32 !== 32'd5)         begin errors++; $display("FAIL dz_rem: got %h expected 00000005", rem32); end
        checks++; if (dz32 !== 1'b1)           begin errors++; $display("FAIL dz_flag: got %b expected 1", dz32); end
        tick();
    endtask

`ifdef DIVIDER_PARAM_SIGNED_EN
    task automatic test_signed();
        int cyc; logic bz;
        run32(32'hFFFF_FFF9, 32'd2, 1'b1, cyc, bz);
        checks++; if (quo32 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sgn_quo: got %h expected fffffffd", quo32); end
        checks++; if (rem32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sgn_rem: got %h expected ffffffff", rem32); end
        tick();
        run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc, bz);
        checks++; if (quo32 !== 32'h8000_0000) begin errors++; $display("FAIL ovf_quo: got %h expected 80000000", quo32); end
        checks++; if (rem32 !== 32'd0)         begin errors++; $display("FAIL ovf_rem: got %h expected 00000000", rem32); end
        checks++; if (dz32 !== 1'b0)           begin errors++; $display("FAIL ovf_dz: got %b expected 0", dz32); end
        tick();
    endtask
`else
    task automatic test_sign_ignored();
        int cyc; logic bz;
        run32(32'hFFFF_FFF9, 32'd2, 1'b1, cyc, bz);
        checks++; if (quo32 !== 32'h7FFF_FFFC) begin errors++; $display("FAIL uns_quo: got %h expected 7ffffffc", quo32); end
        checks++; if (rem32 !== 32'd1)         begin errors++; $display("FAIL uns_rem: got %h expected 00000001", rem32); end
        tick();
    endtask
`endif

    task automatic test_reset_midrun();
        int cyc; logic bz; logic seen;
        a32 = 32'd1000; b32 = 32'd3; sgn32 = 1'b0; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy32 !== 1'b0 || quo32 !== 32'd0 || rem32 !== 32'd0 || dz32 !== 1'b0)
            begin errors++; $display("FAIL midrst_clear: got busy=%b quo=%h rem=%h dz=%b expected all 0", busy32, quo32, rem32, dz32); end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (finish32 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_nofinish: got finish seen=%b expected 0", seen); end
        $display("mid-run reset applied at iteration 10");
        run32(32'd9, 32'd3, 1'b0, cyc, bz);
        checks++; if (cyc != 34)      begin errors++; $display("FAIL midrst_latency: got %0d expected 34", cyc); end
        checks++; if (quo32 !== 32'd3) begin errors++; $display("FAIL midrst_quo: got %h expected 00000003", quo32); end
        checks++; if (rem32 !== 32'd0) begin errors++; $display("FAIL midrst_rem: got %h expected 00000000", rem32); end
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        a8 = 8'd200; b8 = 8'd13; sgn8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'd17; b8 = 8'd17;
        k = 0;
        while (finish8 !== 1'b1 && k < 50) begin tick(); k++; end
        $display("div8 a=200 b=13 -> quo=%0d rem=%0d after %0d cycles", quo8, rem8, k);
        checks++; if (k != 10)        begin errors++; $display("FAIL b2b_lat1: got %0d expected 10", k); end
        checks++; if (quo8 !== 8'd15) begin errors++; $display("FAIL b2b_quo1: got %0d expected 15", quo8); end
        checks++; if (rem8 !== 8'd5)  begin errors++; $display("FAIL b2b_rem1: got %0d expected 5", rem8); end
        tick();
        checks++; if (busy8 !== 1'b0 || finish8 !== 1'b0)
            begin errors++; $display("FAIL b2b_idle: got busy=%b finish=%b expected 0 0", busy8, finish8); end
        tick();
        a8 = 8'd99; b8 = 8'd4;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b expected 1", busy8); end
        k = 0;
        while (finish8 !== 1'b1 && k < 50) begin tick(); k++; end
        start8 = 1'b0;
        $display("div8 a=17 b=17 -> quo=%0d rem=%0d after %0d cycles", quo8, rem8, k);
        checks++; if (k != 10)        begin errors++; $display("FAIL b2b_lat2: got %0d expected 10", k); end
        checks++; if (quo8 !== 8'd1)  begin errors++; $display("FAIL b2b_quo2: got %0d expected 1", quo8); end
        checks++; if (rem8 !== 8'd0)  begin errors++; $display("FAIL b2b_rem2: got %0d expected 0", rem8); end
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_boundary();
`ifdef DIVIDER_PARAM_SIGNED_EN
        test_signed();
`else
        test_sign_ignored();
`endif
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
